pkt_stats_tap: RTL and testbench
================================

PKT_STATS_TAP -- requirements
Module: pkt_stats_tap

Interface
REQ-001 SHALL have parameter AMM_DWIDTH, default 32: Avalon-MM data width.
REQ-002 SHALL have parameter AST_DWIDTH, default 64: Avalon-ST data width, a multiple of 8.
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 1: Avalon-ST channel width.
REQ-004 SHALL have parameter CNT_WIDTH, default 32: statistics counter width, at most AMM_DWIDTH.
REQ-005 SHALL have port clk_i, input, 1: the only clock.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port amm_if, avalon_mm_if.slave, AMM_DWIDTH: register access; uses address, read, write, writedata, readdata, readdatavalid, waitrequest.
REQ-008 SHALL have port sink_if, avalon_st_if.sink, AST_DWIDTH: packet input from the packet filter output.
REQ-009 SHALL have port src_if, avalon_st_if.src, AST_DWIDTH: packet output to the next stage.

Function
REQ-010 SHALL pass data, startofpacket, endofpacket, empty and channel through one output register stage, unmodified, with a latency of 1 cycle.
REQ-011 SHALL drive sink_if.ready = !src_if.valid || src_if.ready, combinationally.
REQ-012 SHALL load the stage on a sink transfer (valid && ready), and SHALL clear src_if.valid on a src transfer with no simultaneous sink transfer.
REQ-013 SHALL hold src_if payload stable while src_if.valid && !src_if.ready.
REQ-014 SHALL evaluate all counters on src transfers (src valid && ready) only, and only while CTRL.en = 1.
REQ-015 SHALL make PKT_CNT count beats with endofpacket = 1.
REQ-016 SHALL make ERR_CNT count violations: startofpacket while in-packet (missing eop), or a data beat while not in-packet (missing sop).
REQ-017 SHALL track the in-packet flag as follows: set on a sop beat, cleared on an eop beat; a sop+eop beat leaves it clear.
REQ-018 SHALL make STALL_CNT count cycles with src_if.valid && !src_if.ready, regardless of transfer.
REQ-019 SHALL saturate every counter at 2^CNT_WIDTH-1; there is no wrap-around.
REQ-020 SHALL decode the register map on amm_if.address as word indices:
  - 0 CTRL: bit0 en (R/W, reset 1), bit1 clr (W1 pulse, reads 0).
  - 1 PKT_CNT (RO).
  - 2 BYTE_CNT (RO).
  - 3 ERR_CNT (RO).
  - 4 STALL_CNT (RO).
  - All other addresses: read 0, writes ignored.
REQ-021 SHALL tie amm_if.waitrequest to 0.
REQ-022 SHALL return readdata with readdatavalid = 1 exactly one cycle after read; both are registered, and readdatavalid is otherwise 0.
REQ-023 SHALL zero all counters and the in-packet flag on the next edge after a write of clr = 1; clear SHALL win over a same-cycle increment.
REQ-024 SHALL return, on a read coinciding with an increment, the pre-increment value.
REQ-025 SHALL count in-flight payload bits as data only; no packet is dropped or altered by the block.

Reset
REQ-026 SHALL, while rst_i is asserted, asynchronously force: src_if.valid = 0, readdatavalid = 0, readdata = 0, all counters = 0, in-packet flag = 0, CTRL.en = 1.
REQ-027 SHALL discard the beat held in the output stage on reset mid-packet; after release, the first accepted beat without sop SHALL increment ERR_CNT.

Configuration
REQ-028 SHALL compile in BYTE_CNT when macro PKT_STATS_BYTE_CNT_EN is defined:
  - Adds AST_DWIDTH/8 per non-eop transfer.
  - Adds AST_DWIDTH/8 - empty per eop transfer.
  - Saturates per REQ-019.
REQ-029 SHALL, without PKT_STATS_BYTE_CNT_EN, contain no byte-count logic; address 2 reads 0.

Verification
REQ-030 SHALL cover: 3 packets of 2 beats, empty = 3 on eop, src ready = 1 -> PKT_CNT = 3, BYTE_CNT = 39 (macro on) / 0 (macro off), ERR_CNT = 0, each beat appears 1 cycle after input.
REQ-031 SHALL cover: src ready low for 5 cycles mid-packet -> STALL_CNT = 5, payload stable, sink ready = 0 while held, no beat lost or duplicated.
REQ-032 SHALL cover: sop, sop, eop sequence -> ERR_CNT = 1, PKT_CNT = 1.
REQ-033 SHALL cover: write CTRL = 0x2 in the same cycle as an eop transfer -> PKT_CNT reads 0 afterwards; write CTRL = 0x0, then send 1 packet -> PKT_CNT stays 0.
REQ-034 SHALL cover: CNT_WIDTH = 4 with 20 packets -> PKT_CNT = 15; read address 7 -> 0 with readdatavalid one cycle after read.
REQ-035 SHALL cover: rst_i pulsed mid-packet -> src_if.valid = 0 immediately; all counters 0; next non-sop beat -> ERR_CNT = 1.

Source files
------------

// File: rtl/pkt_stats_tap_if.sv
// Avalon-MM and Avalon-ST interface bundles used by pkt_stats_tap.
//   avalon_mm_if : address/read/write/writedata/readdata/readdatavalid/waitrequest
//                  modports: slave (register block side), master (host side)
//   avalon_st_if : data/valid/ready/startofpacket/endofpacket/empty/channel
//                  modports: sink (consumer side), src (producer side)

interface avalon_mm_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
);
    logic [AWIDTH-1:0] address;
    logic              read;
    logic              write;
    logic [DWIDTH-1:0] writedata;
    logic [DWIDTH-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );
endinterface

interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int EMPTY_WIDTH   = 3
);
    logic [DWIDTH-1:0]        data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport sink (
        input  data, valid, startofpacket, endofpacket, empty, channel,
        output ready
    );
    modport src (
        output data, valid, startofpacket, endofpacket, empty, channel,
        input  ready
    );
endinterface

// File: rtl/pkt_stats_tap.sv
// pkt_stats_tap: one-stage pass-through register on an Avalon-ST stream that
// gathers packet statistics, readable over an Avalon-MM slave.
//
// Ports:
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   amm_if   : avalon_mm_if.slave  register access (word addresses)
//                0 CTRL (bit0 en R/W reset 1, bit1 clr W1 pulse), 1 PKT_CNT,
//                2 BYTE_CNT, 3 ERR_CNT, 4 STALL_CNT, others read 0
//   sink_if  : avalon_st_if.sink   packet input
//   src_if   : avalon_st_if.src    packet output, 1 cycle latency
//
// Optional feature: define PKT_STATS_BYTE_CNT_EN to build the byte counter;
// otherwise address 2 reads 0 and no byte-count logic exists.
// The address bus of amm_if is expected to be 4 bits wide.

module pkt_stats_tap #(
    parameter int AMM_DWIDTH    = 32,
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int CNT_WIDTH     = 32
) (
    input logic        clk_i,
    input logic        rst_i,
    avalon_mm_if.slave amm_if,
    avalon_st_if.sink  sink_if,
    avalon_st_if.src   src_if
);

    localparam int BYTES       = AST_DWIDTH / 8;
    localparam int EMPTY_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Saturating add: a sum beyond the counter range clamps at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [15:0]          inc
    );
        logic [CNT_WIDTH+16:0] sum;
        sum = {17'd0, cnt} + {{(CNT_WIDTH + 1){1'b0}}, inc};
        if (sum > {17'd0, CNT_MAX}) begin
            return CNT_MAX;
        end else begin
            return sum[CNT_WIDTH-1:0];
        end
    endfunction

    // Output stage
    logic                     src_valid_q, src_valid_d;
    logic [AST_DWIDTH-1:0]    src_data_q;
    logic                     src_sop_q;
    logic                     src_eop_q;
    logic [EMPTY_WIDTH-1:0]   src_empty_q;
    logic [CHANNEL_WIDTH-1:0] src_channel_q;

    // Control and statistics
    logic                 en_q, en_d;
    logic                 in_pkt_q, in_pkt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
`ifdef PKT_STATS_BYTE_CNT_EN
    logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]          byte_inc_s;
`endif

    // Register read path
    logic                  rdvalid_q;
    logic [AMM_DWIDTH-1:0] rdata_q, rdata_d, rd_mux_s;

    logic       sink_ready_s, sink_xfer_s, src_xfer_s, src_stall_s;
    logic       ctrl_wr_s, clr_s, err_s;
    logic [3:0] addr_s;
    logic       unused_wdata_s;

    assign addr_s         = amm_if.address;
    assign sink_ready_s   = !src_valid_q || src_if.ready;
    assign sink_xfer_s    = sink_if.valid && sink_ready_s;
    assign src_xfer_s     = src_valid_q && src_if.ready;
    assign src_stall_s    = src_valid_q && !src_if.ready;
    assign ctrl_wr_s      = amm_if.write && (addr_s == 4'd0);
    assign clr_s          = ctrl_wr_s && amm_if.writedata[1];
    assign unused_wdata_s = ^amm_if.writedata[AMM_DWIDTH-1:2];
    // A sop inside a packet lost its eop; a non-sop beat outside a packet lost its sop.
    assign err_s          = src_sop_q ? in_pkt_q : !in_pkt_q;

    assign sink_if.ready        = sink_ready_s;
    assign src_if.valid         = src_valid_q;
    assign src_if.data          = src_data_q;
    assign src_if.startofpacket = src_sop_q;
    assign src_if.endofpacket   = src_eop_q;
    assign src_if.empty         = src_empty_q;
    assign src_if.channel       = src_channel_q;
    assign amm_if.waitrequest   = 1'b0;
    assign amm_if.readdata      = rdata_q;
    assign amm_if.readdatavalid = rdvalid_q;

    // Output stage valid: a new beat takes priority over the beat leaving.
    always_comb begin
        src_valid_d = src_valid_q;
        if (sink_xfer_s) begin
            src_valid_d = 1'b1;
        end else if (src_xfer_s) begin
            src_valid_d = 1'b0;
        end else begin
            src_valid_d = src_valid_q;
        end
    end

    // Statistics next-state; clr overrides every increment.
    always_comb begin
        en_d        = ctrl_wr_s ? amm_if.writedata[0] : en_q;
        in_pkt_d    = in_pkt_q;
        pkt_cnt_d   = pkt_cnt_q;
        err_cnt_d   = err_cnt_q;
        stall_cnt_d = stall_cnt_q;
`ifdef PKT_STATS_BYTE_CNT_EN
        byte_cnt_d  = byte_cnt_q;
        byte_inc_s  = src_eop_q ? (16'(BYTES) - 16'(src_empty_q)) : 16'(BYTES);
`endif
        if (clr_s) begin
            in_pkt_d    = 1'b0;
            pkt_cnt_d   = '0;
            err_cnt_d   = '0;
            stall_cnt_d = '0;
`ifdef PKT_STATS_BYTE_CNT_EN
            byte_cnt_d  = '0;
`endif
        end else begin
            if (src_xfer_s) begin
                if (src_eop_q) begin
                    in_pkt_d = 1'b0;
                end else if (src_sop_q) begin
                    in_pkt_d = 1'b1;
                end else begin
                    in_pkt_d = in_pkt_q;
                end
            end else begin
                in_pkt_d = in_pkt_q;
            end
            if (en_q) begin
                if (src_xfer_s) begin
                    pkt_cnt_d  = src_eop_q ? sat_add(pkt_cnt_q, 16'd1) : pkt_cnt_q;
                    err_cnt_d  = err_s ? sat_add(err_cnt_q, 16'd1) : err_cnt_q;
`ifdef PKT_STATS_BYTE_CNT_EN
                    byte_cnt_d = sat_add(byte_cnt_q, byte_inc_s);
`endif
                end else begin
                    pkt_cnt_d = pkt_cnt_q;
                end
                stall_cnt_d = src_stall_s ? sat_add(stall_cnt_q, 16'd1) : stall_cnt_q;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // Register read mux; the registered counter gives the pre-increment value.
    always_comb begin
        rd_mux_s = '0;
        case (addr_s)
            4'd0:    rd_mux_s[1:0] = {1'b0, en_q};
            4'd1:    rd_mux_s[CNT_WIDTH-1:0] = pkt_cnt_q;
`ifdef PKT_STATS_BYTE_CNT_EN
            4'd2:    rd_mux_s[CNT_WIDTH-1:0] = byte_cnt_q;
`endif
            4'd3:    rd_mux_s[CNT_WIDTH-1:0] = err_cnt_q;
            4'd4:    rd_mux_s[CNT_WIDTH-1:0] = stall_cnt_q;
            default: rd_mux_s = '0;
        endcase
        rdata_d = amm_if.read ? rd_mux_s : '0;
    end

    // Output stage payload and valid registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src_valid_q   <= 1'b0;
            src_data_q    <= '0;
            src_sop_q     <= 1'b0;
            src_eop_q     <= 1'b0;
            src_empty_q   <= '0;
            src_channel_q <= '0;
        end else begin
            src_valid_q <= src_valid_d;
            if (sink_xfer_s) begin
                src_data_q    <= sink_if.data;
                src_sop_q     <= sink_if.startofpacket;
                src_eop_q     <= sink_if.endofpacket;
                src_empty_q   <= sink_if.empty;
                src_channel_q <= sink_if.channel;
            end
        end
    end

    // Control, statistics and read-response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q        <= 1'b1;
            in_pkt_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            stall_cnt_q <= '0;
`ifdef PKT_STATS_BYTE_CNT_EN
            byte_cnt_q  <= '0;
`endif
            rdvalid_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            en_q        <= en_d;
            in_pkt_q    <= in_pkt_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef PKT_STATS_BYTE_CNT_EN
            byte_cnt_q  <= byte_cnt_d;
`endif
            rdvalid_q   <= amm_if.read;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_pkt_stats_tap.sv
module tb_pkt_stats_tap;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        in_valid  = 1'b0;
    logic        in_sop    = 1'b0;
    logic        in_eop    = 1'b0;
    logic [2:0]  in_empty  = 3'd0;
    logic [63:0] in_data   = 64'd0;
    logic        out_ready = 1'b1;
    logic        sel2      = 1'b0;
    logic [3:0]  mm_addr   = 4'd0;
    logic        mm_read   = 1'b0;
    logic        mm_write  = 1'b0;
    logic [31:0] mm_wdata  = 32'd0;

    int checks   = 0;
    int failures = 0;

    avalon_mm_if #(.DWIDTH(32), .AWIDTH(4)) amm1 ();
    avalon_mm_if #(.DWIDTH(32), .AWIDTH(4)) amm2 ();
    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(3)) snk1 ();
    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(3)) src1 ();
    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(3)) snk2 ();
    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1), .EMPTY_WIDTH(3)) src2 ();

    assign snk1.valid         = in_valid & ~sel2;
    assign snk1.data          = in_data;
    assign snk1.startofpacket = in_sop;
    assign snk1.endofpacket   = in_eop;
    assign snk1.empty         = in_empty;
    assign snk1.channel       = 1'b0;
    assign snk2.valid         = in_valid & sel2;
    assign snk2.data          = in_data;
    assign snk2.startofpacket = in_sop;
    assign snk2.endofpacket   = in_eop;
    assign snk2.empty         = in_empty;
    assign snk2.channel       = 1'b0;
    assign src1.ready         = out_ready;
    assign src2.ready         = 1'b1;
    assign amm1.address       = mm_addr;
    assign amm1.read          = mm_read & ~sel2;
    assign amm1.write         = mm_write & ~sel2;
    assign amm1.writedata     = mm_wdata;
    assign amm2.address       = mm_addr;
    assign amm2.read          = mm_read & sel2;
    assign amm2.write         = mm_write & sel2;
    assign amm2.writedata     = mm_wdata;

    pkt_stats_tap #(.AMM_DWIDTH(32), .AST_DWIDTH(64), .CHANNEL_WIDTH(1), .CNT_WIDTH(32)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .amm_if(amm1), .sink_if(snk1), .src_if(src1));
    pkt_stats_tap #(.AMM_DWIDTH(32), .AST_DWIDTH(64), .CHANNEL_WIDTH(1), .CNT_WIDTH(4)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .amm_if(amm2), .sink_if(snk2), .src_if(src2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one beat and hold it until the selected DUT accepts it.
    task automatic send_beat(input logic sop, input logic eop, input logic [2:0] emp,
                             input logic [63:0] dat);
        logic ok;
        logic rdy;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_sop   = sop;
        in_eop   = eop;
        in_empty = emp;
        in_data  = dat;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk_i);
            rdy = sel2 ? snk2.ready : snk1.ready;
            @(posedge clk_i);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        check("sink_accept", 64'(ok), 64'd1);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        mm_addr = a;
        mm_read = 1'b1;
        tick();
        mm_read = 1'b0;
        check("rd_valid", 64'(sel2 ? amm2.readdatavalid : amm1.readdatavalid), 64'd1);
        check(tag, 64'(sel2 ? amm2.readdata : amm1.readdata), 64'(exp));
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        mm_addr  = a;
        mm_wdata = d;
        mm_write = 1'b1;
        tick();
        mm_write = 1'b0;
    endtask

    logic [31:0] exp_bytes;
    logic [31:0] exp_bytes_sat;

    initial begin
`ifdef PKT_STATS_BYTE_CNT_EN
        exp_bytes     = 32'd39;
        exp_bytes_sat = 32'd15;
`else
        exp_bytes     = 32'd0;
        exp_bytes_sat = 32'd0;
`endif
        // Reset state
        #1;
        check("rst_src_valid", 64'(src1.valid), 64'd0);
        check("rst_rdvalid", 64'(amm1.readdatavalid), 64'd0);
        check("rst_rdata", 64'(amm1.readdata), 64'd0);
        check("waitrequest", 64'(amm1.waitrequest), 64'd0);
        tick();
        tick();
        rst_i = 1'b0;
        rd_check("rst_ctrl", 4'd0, 32'd1);
        rd_check("rst_pkt", 4'd1, 32'd0);

        // Three 2-beat packets, empty = 3 on eop, output always ready
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 2; b++) begin
                send_beat(b == 0, b == 1, (b == 1) ? 3'd3 : 3'd0, 64'hA000_0000_0000_0000 + 64'(p * 2 + b));
                check("lat_valid", 64'(src1.valid), 64'd1);
                check("lat_data", src1.data, 64'hA000_0000_0000_0000 + 64'(p * 2 + b));
                check("lat_eop", 64'(src1.endofpacket), 64'(b == 1));
            end
        end
        tick();
        rd_check("p3_pkt", 4'd1, 32'd3);
        rd_check("p3_byte", 4'd2, exp_bytes);
        rd_check("p3_err", 4'd3, 32'd0);
        rd_check("p3_stall", 4'd4, 32'd0);

        // Output stalled 5 cycles mid-packet
        out_ready = 1'b0;
        send_beat(1'b1, 1'b0, 3'd0, 64'h1111);
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'b1;
        in_empty = 3'd0;
        in_data  = 64'h2222;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", src1.data, 64'h1111);
            check("stall_valid", 64'(src1.valid), 64'd1);
            check("stall_sink_rdy", 64'(snk1.ready), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("stall_next_data", src1.data, 64'h2222);
        check("stall_next_valid", 64'(src1.valid), 64'd1);
        tick();
        check("stall_drained", 64'(src1.valid), 64'd0);
        rd_check("stall_cnt", 4'd4, 32'd5);
        rd_check("stall_pkt", 4'd1, 32'd4);
        rd_check("stall_err", 4'd3, 32'd0);

        // clr written in the same cycle as an eop transfer
        out_ready = 1'b0;
        send_beat(1'b1, 1'b1, 3'd0, 64'h3333);
        out_ready = 1'b1;
        mm_addr   = 4'd0;
        mm_wdata  = 32'h2;
        mm_write  = 1'b1;
        tick();
        mm_write = 1'b0;
        rd_check("clr_pkt", 4'd1, 32'd0);
        rd_check("clr_stall", 4'd4, 32'd0);
        rd_check("clr_ctrl", 4'd0, 32'd0);
        wr_reg(4'd0, 32'h0);
        send_beat(1'b1, 1'b1, 3'd0, 64'h4444);
        tick();
        rd_check("dis_pkt", 4'd1, 32'd0);
        wr_reg(4'd0, 32'h1);
        rd_check("en_ctrl", 4'd0, 32'd1);

        // sop, sop, eop
        send_beat(1'b1, 1'b0, 3'd0, 64'h5551);
        send_beat(1'b1, 1'b0, 3'd0, 64'h5552);
        send_beat(1'b0, 1'b1, 3'd0, 64'h5553);
        tick();
        rd_check("sse_err", 4'd3, 32'd1);
        rd_check("sse_pkt", 4'd1, 32'd1);

        // Reset mid-packet
        out_ready = 1'b0;
        send_beat(1'b1, 1'b0, 3'd0, 64'h6666);
        check("pre_rst_valid", 64'(src1.valid), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_valid", 64'(src1.valid), 64'd0);
        tick();
        tick();
        rst_i     = 1'b0;
        out_ready = 1'b1;
        rd_check("mrst_pkt", 4'd1, 32'd0);
        rd_check("mrst_err", 4'd3, 32'd0);
        rd_check("mrst_stall", 4'd4, 32'd0);
        rd_check("mrst_ctrl", 4'd0, 32'd1);
        send_beat(1'b0, 1'b0, 3'd0, 64'h7777);
        tick();
        rd_check("mrst_nosop_err", 4'd3, 32'd1);

        // 4-bit counters saturate
        sel2 = 1'b1;
        for (int p = 0; p < 20; p++) begin
            send_beat(1'b1, 1'b1, 3'd0, 64'(p));
        end
        tick();
        rd_check("sat_pkt", 4'd1, 32'd15);
        rd_check("sat_byte", 4'd2, exp_bytes_sat);
        rd_check("sat_err", 4'd3, 32'd0);
        rd_check("addr7", 4'd7, 32'd0);
        tick();
        check("rdvalid_drop", 64'(amm2.readdatavalid), 64'd0);
        sel2 = 1'b0;
        rd_check("addr7_dut1", 4'd7, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
